// File: rtl/bufg_div_pkg.sv
// Shared defaults and ratio helpers for the dividing global clock buffer model.
// A divide code d always selects the ratio N = d + 1.
package bufg_div_pkg;

    localparam int DEFAULT_DIV_W = 3;
    localparam int CODE_W        = 8;

    // High-phase length in whole input cycles for the ratio selected by code.
    function automatic logic [CODE_W:0] half_of(input logic [CODE_W-1:0] code);
        logic [CODE_W:0] ratio;
        ratio = (CODE_W+1)'(code) + (CODE_W+1)'(1);
        return ratio >> 1;
    endfunction

    function automatic logic is_odd_ratio(input logic [CODE_W-1:0] code);
        return {half_of(code), 1'b0} != ((CODE_W+2)'(code) + (CODE_W+2)'(1));
    endfunction

endpackage

// File: rtl/bufg_div_chan.sv
// One gated, dividing clock channel.
// The divide ratio and the enable are only acted on at period boundaries.
module bufg_div_chan
    import bufg_div_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             I,
    input  logic             CLR,
    input  logic [DIV_W-1:0] DIV,
    input  logic             CE,
    input  logic             CEMASK,
    (* clocker *)
    output logic             O,
    output logic             TC
);

    logic [1:0]       ce_sync;
    logic             ce_eff;
    logic             ce_lat;
    logic             armed;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] cnt;
    logic             o_pos;
    logic             o_neg;

    logic             boundary;
    logic             start;
    logic             running;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] cnt_next;
    logic             o_pos_next;

    // With cnt at 0 a live period always has o_pos high, so cnt==0 with o_pos low means idle.
    always_comb begin
        ce_eff   = ce_sync[1] | CEMASK;
        boundary = (cnt == div_act) || ((cnt == '0) && !o_pos);
        start    = armed && boundary && ce_lat;
        running  = armed && (start || !boundary);
        div_next = div_act;
        cnt_next = cnt;
        if (!armed || boundary) begin
            div_next = DIV;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + DIV_W'(1);
        end
        o_pos_next = running && ((CODE_W+1)'(cnt_next) < half_of(CODE_W'(div_next)));
    end

    always_ff @(posedge I or posedge CLR) begin
        if (CLR) begin
            ce_sync <= '0;
            armed   <= 1'b0;
            div_act <= '0;
            cnt     <= '0;
            o_pos   <= 1'b0;
            TC      <= 1'b0;
        end else begin
            ce_sync <= {ce_sync[0], CE};
            armed   <= 1'b1;
            div_act <= div_next;
            cnt     <= cnt_next;
            o_pos   <= o_pos_next;
            TC      <= start;
        end
    end

    // Falling-edge copies: the enable latch keeps divide-by-1 free of runts,
    // and o_neg supplies the extra half cycle for odd ratios.
    always_ff @(negedge I or posedge CLR) begin
        if (CLR) begin
            ce_lat <= 1'b0;
            o_neg  <= 1'b0;
        end else begin
            ce_lat <= ce_eff & armed;
            o_neg  <= o_pos;
        end
    end

    always_comb begin
        if (div_act == '0) begin
            O = I & ce_lat;
        end else begin
            O = o_pos | (o_neg & is_odd_ratio(CODE_W'(div_act)));
        end
    end

endmodule

// File: rtl/bufg_div_multi.sv
// Multi-channel gated, dividing global clock buffer: NUM_CH independent channels
// sharing one source clock and reset, so channels armed together stay phase-aligned.
module bufg_div_multi
    import bufg_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DEFAULT_DIV_W
) (
    input  logic                    I,
    input  logic                    CLR,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic [NUM_CH-1:0]       CE,
    input  logic [NUM_CH-1:0]       CEMASK,
    (* clocker *)
    output logic [NUM_CH-1:0]       O,
    output logic [NUM_CH-1:0]       TC
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        bufg_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .I      (I),
            .CLR    (CLR),
            .DIV    (DIV[n*DIV_W +: DIV_W]),
            .CE     (CE[n]),
            .CEMASK (CEMASK[n]),
            .O      (O[n]),
            .TC     (TC[n])
        );
    end

endmodule
